// File: rtl/rv_lsu_pkg.sv
// Shared constants and FSM state type for the RV32I MEM-stage
// load/store unit.
package rv_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

endpackage

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension of a bus read word.
// Offending offset bits select the naturally aligned lane.
module load_extend
  import rv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[7:0];
    unique case (offset)
      2'd0: lane_b = rdata[7:0];
      2'd1: lane_b = rdata[15:8];
      2'd2: lane_b = rdata[23:16];
      2'd3: lane_b = rdata[31:24];
    endcase
    lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    unique case (funct3)
      F3_LB:   data = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_LH:   data = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, lane_b};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, lane_h};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage data-memory access engine (ready/valid bus, stall control).
// Define MISALIGN_TRAP_EN to trap misaligned halves/words instead of force-aligning.
module load_store_unit
  import rv_lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_LSB = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemRd_MEM,
  input  logic            MemWr_MEM,
  input  logic [2:0]      funct3_MEM,
  input  logic [XLEN-1:0] Alu_out_MEM,
  input  logic [XLEN-1:0] rs2_data_MEM,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_ready,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] Data_Load_WB,
  output logic            stall_MEM,
  output logic            misalign_MEM
);

  lsu_state_t state, state_nx;

  logic            access;
  logic            is_store;
  logic            misaligned;
  logic            latch;
  logic            capture;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_wstrb;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      f3_q;
  logic            we_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      wstrb_q;
  logic [XLEN-1:0] load_ext;

  assign access   = MemRd_MEM | MemWr_MEM;
  assign is_store = MemWr_MEM & ~MemRd_MEM;

  // Store data is replicated across lanes; strobes pick the live bytes.
  always_comb begin
    st_wdata = rs2_data_MEM;
    st_wstrb = 4'b1111;
    unique case (funct3_MEM[1:0])
      F3_SB[1:0]: begin
        st_wdata = {4{rs2_data_MEM[7:0]}};
        st_wstrb = 4'b0001 << Alu_out_MEM[1:0];
      end
      F3_SH[1:0]: begin
        st_wdata = {2{rs2_data_MEM[15:0]}};
        st_wstrb = 4'b0011 << {Alu_out_MEM[1], 1'b0};
      end
      F3_SW[1:0], 2'b11: begin
        st_wdata = rs2_data_MEM;
        st_wstrb = 4'b1111;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_q;

  always_comb begin
    misaligned = 1'b0;
    unique case (funct3_MEM[1:0])
      F3_SB[1:0]: misaligned = 1'b0;
      F3_SH[1:0]: misaligned = Alu_out_MEM[0];
      F3_SW[1:0], 2'b11: misaligned = |Alu_out_MEM[1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (state == IDLE) begin
      mis_q <= access & misaligned;
    end
  end

  assign misalign_MEM = (state == DONE) & mis_q;
`else
  assign misaligned   = 1'b0;
  assign misalign_MEM = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    capture  = 1'b0;
    unique case (state)
      IDLE: begin
        if (access) begin
          latch    = ~misaligned;
          state_nx = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        if (dmem_ready) state_nx = we_q ? DONE : WAIT;
      end
      WAIT: begin
        if (dmem_rvalid) begin
          capture  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (latch) begin
      addr_q  <= Alu_out_MEM;
      f3_q    <= funct3_MEM;
      we_q    <= is_store;
      wdata_q <= st_wdata;
      wstrb_q <= is_store ? st_wstrb : 4'b0000;
    end
  end

  load_extend #(
    .XLEN(XLEN)
  ) u_ext (
    .rdata (dmem_rdata),
    .funct3(f3_q),
    .offset(addr_q[1:0]),
    .data  (load_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          Data_Load_WB <= '0;
    else if (capture) Data_Load_WB <= load_ext;
  end

  assign dmem_req   = (state == REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[XLEN-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;

  assign stall_MEM = ((state == IDLE) & access)
                   | (state == REQ)
                   | (state == WAIT);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level memory model,
// random bus latency, decoupled bus/writeback monitor.
module tb_load_store_unit;
  import rv_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemRd_MEM = 1'b0;
  logic        MemWr_MEM = 1'b0;
  logic [2:0]  funct3_MEM = '0;
  logic [31:0] Alu_out_MEM = '0;
  logic [31:0] rs2_data_MEM = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] Data_Load_WB;
  logic        stall_MEM;
  logic        misalign_MEM;

  bit          manual = 1'b1;
  logic        man_ready = 1'b0;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata = '0;
  logic        auto_ready = 1'b0;
  logic        auto_rvalid = 1'b0;
  logic [31:0] auto_rdata = '0;

  assign dmem_ready  = manual ? man_ready  : auto_ready;
  assign dmem_rvalid = manual ? man_rvalid : auto_rvalid;
  assign dmem_rdata  = manual ? man_rdata  : auto_rdata;

  initial forever #5 clk = ~clk;

  load_store_unit dut (
    .clk         (clk),
    .rst         (rst),
    .MemRd_MEM   (MemRd_MEM),
    .MemWr_MEM   (MemWr_MEM),
    .funct3_MEM  (funct3_MEM),
    .Alu_out_MEM (Alu_out_MEM),
    .rs2_data_MEM(rs2_data_MEM),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_wstrb  (dmem_wstrb),
    .dmem_ready  (dmem_ready),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .Data_Load_WB(Data_Load_WB),
    .stall_MEM   (stall_MEM),
    .misalign_MEM(misalign_MEM)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  typedef struct {
    logic [31:0] val;
    logic        mis;
  } done_t;

  bus_t        exp_bus[$];
  done_t       exp_done[$];
  int          total = 0;
  int          bad = 0;
  logic [7:0]  ref_mem[256];
  logic [31:0] bus_mem[64];
  logic [31:0] last_load = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte-addressed memory, sizes in bytes, aligned base.
  task automatic set_op(input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
    int sz;
    int base;
    bit sgn;
    bit st;
    bit mis;
    logic [31:0] v;
    bus_t b;
    done_t e;
    st  = wr && !rd;
    sgn = 1'b0;
    if (st) begin
      sz = (f3 == F3_SB) ? 1 : (f3 == F3_SH) ? 2 : 4;
    end else begin
      case (f3)
        F3_LB:   begin sz = 1; sgn = 1'b1; end
        F3_LH:   begin sz = 2; sgn = 1'b1; end
        F3_LBU:  sz = 1;
        F3_LHU:  sz = 2;
        default: sz = 4;
      endcase
    end
    base = int'(a[7:0]) / sz * sz;
    mis  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = (int'(a[7:0]) % sz) != 0;
`endif
    if (!mis) begin
      b.we    = st;
      b.addr  = a & 32'hFFFF_FFFC;
      b.wdata = '0;
      b.wstrb = '0;
      if (st) begin
        for (int k = 0; k < sz; k++) begin
          b.wstrb[(base + k) % 4] = 1'b1;
          ref_mem[base + k] = d[8*k +: 8];
        end
        for (int j = 0; j < 4; j++) b.wdata[8*j +: 8] = d[8*(j % sz) +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_mem[base + k];
        if (sgn && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (sgn && sz == 2) v = {{16{v[15]}}, v[15:0]};
        last_load = v;
      end
      exp_bus.push_back(b);
    end
    e.val = last_load;
    e.mis = mis;
    exp_done.push_back(e);
    MemRd_MEM    = rd;
    MemWr_MEM    = wr;
    funct3_MEM   = f3;
    Alu_out_MEM  = a;
    rs2_data_MEM = d;
  endtask

  task automatic wait_done(input int gap);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall_MEM && n < 80);
    if (stall_MEM) begin
      total++;
      bad++;
      $display("FAIL timeout: stall_MEM still 1 after %0d cycles", n);
    end
    @(posedge clk); #1;
    MemRd_MEM = 1'b0;
    MemWr_MEM = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int gap);
    set_op(rd, wr, f3, a, d);
    wait_done(gap);
  endtask

  // Bus slave: random ready, read data 1-3 cycles after the handshake.
  initial begin
    bit          rd_pend = 1'b0;
    int          rd_wait = 0;
    logic [31:0] rd_word = '0;
    int          idx;
    forever begin
      @(negedge clk);
      if (!manual && !rst && dmem_req && dmem_ready) begin
        idx = int'(dmem_addr[7:2]);
        if (dmem_we) begin
          for (int j = 0; j < 4; j++)
            if (dmem_wstrb[j]) bus_mem[idx][8*j +: 8] = dmem_wdata[8*j +: 8];
        end else begin
          rd_pend = 1'b1;
          rd_word = bus_mem[idx];
          rd_wait = $urandom_range(0, 2);
        end
      end
      @(posedge clk); #1;
      auto_rvalid = 1'b0;
      auto_rdata  = $urandom;
      if (rd_pend) begin
        if (rd_wait == 0) begin
          auto_rvalid = 1'b1;
          auto_rdata  = rd_word;
          rd_pend     = 1'b0;
        end else begin
          rd_wait--;
        end
      end
      auto_ready = dmem_req && ($urandom_range(0, 3) != 0);
    end
  end

  logic  prev_stall = 1'b0;
  logic  prev_hold = 1'b0;
  bus_t  hold;
  bus_t  mb;
  done_t md;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_addr", dmem_addr, hold.addr);
        chk("hold_wdata", dmem_wdata, hold.wdata);
        chk("hold_ctl", {26'b0, dmem_req, dmem_we, dmem_wstrb},
            {26'b0, 1'b1, hold.we, hold.wstrb});
      end
      if (dmem_req && dmem_ready) begin
        if (exp_bus.size() == 0) begin
          total++;
          bad++;
          $display("FAIL bus_extra: unexpected request addr %h", dmem_addr);
        end else begin
          mb = exp_bus.pop_front();
          chk("bus_we", {31'b0, dmem_we}, {31'b0, mb.we});
          chk("bus_addr", dmem_addr, mb.addr);
          chk("bus_wstrb", {28'b0, dmem_wstrb}, {28'b0, mb.wstrb});
          if (mb.we) chk("bus_wdata", dmem_wdata, mb.wdata);
        end
      end
      prev_hold  = dmem_req && !dmem_ready;
      hold.we    = dmem_we;
      hold.addr  = dmem_addr;
      hold.wdata = dmem_wdata;
      hold.wstrb = dmem_wstrb;
      if (prev_stall && !stall_MEM) begin
        if (exp_done.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_extra: stall released with nothing pending");
        end else begin
          md = exp_done.pop_front();
          chk("load_wb", Data_Load_WB, md.val);
          chk("misalign", {31'b0, misalign_MEM}, {31'b0, md.mis});
        end
      end else if (misalign_MEM) begin
        total++;
        bad++;
        $display("FAIL misalign_stray: got 1 want 0 at %0t", $time);
      end
      prev_stall = stall_MEM;
    end
  end

  logic [2:0] ld_f3[8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
  logic [2:0] st_f3[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

  initial begin
    logic [31:0] w;
    int          r;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (i == 16) w = 32'h80FF_1234;
      bus_mem[i] = w;
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_we", {31'b0, dmem_we}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wstrb", {28'b0, dmem_wstrb}, 32'd0);
    chk("rst_load", Data_Load_WB, 32'd0);
    chk("rst_mis", {31'b0, misalign_MEM}, 32'd0);
    chk("rst_stall", {31'b0, stall_MEM}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Slow load: ready low 3 REQ cycles, rvalid 2 cycles after ready.
    set_op(1'b1, 1'b0, F3_LB, 32'hABCD_0043, 32'd0);
    @(negedge clk);
    chk("lat_idle_stall", {31'b0, stall_MEM}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("lat_req", {30'b0, dmem_req, stall_MEM}, 32'd3);
    end
    @(posedge clk); #1;
    man_ready = 1'b1;
    @(negedge clk);
    chk("lat_req_rdy", {30'b0, dmem_req, stall_MEM}, 32'd3);
    @(posedge clk); #1;
    man_ready = 1'b0;
    @(negedge clk);
    chk("lat_wait1", {30'b0, dmem_req, stall_MEM}, 32'd1);
    @(posedge clk); #1;
    man_rvalid = 1'b1;
    man_rdata  = bus_mem[16];
    @(negedge clk);
    chk("lat_wait2", {30'b0, dmem_req, stall_MEM}, 32'd1);
    @(posedge clk); #1;
    man_rvalid = 1'b0;
    @(negedge clk);
    chk("lat_done", {31'b0, stall_MEM}, 32'd0);
    @(posedge clk); #1;
    MemRd_MEM = 1'b0;

    // Reset while waiting for read data; late rvalid must be dropped.
    mb.we = 1'b0;
    mb.addr = 32'h0000_0080;
    mb.wdata = '0;
    mb.wstrb = '0;
    exp_bus.push_back(mb);
    MemRd_MEM   = 1'b1;
    funct3_MEM  = F3_LW;
    Alu_out_MEM = 32'h0000_0080;
    @(posedge clk); #1;
    man_ready = 1'b1;
    @(posedge clk); #1;
    man_ready = 1'b0;
    @(negedge clk);
    chk("rw_wait", {30'b0, dmem_req, stall_MEM}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    MemRd_MEM = 1'b0;
    last_load = '0;
    #1;
    chk("rw_async_req", {31'b0, dmem_req}, 32'd0);
    chk("rw_async_load", Data_Load_WB, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    man_rvalid = 1'b1;
    man_rdata  = 32'h1234_5678;
    @(posedge clk); #1;
    man_rvalid = 1'b0;
    @(negedge clk);
    chk("rw_load", Data_Load_WB, last_load);
    chk("rw_idle", {30'b0, dmem_req, stall_MEM}, 32'd0);
    @(posedge clk); #1;
    manual = 1'b0;

    issue(1'b1, 1'b0, F3_LBU, 32'hABCD_0043, 32'd0, 1);
    issue(1'b0, 1'b1, F3_SH, 32'h1000_0002, 32'hDEAD_BEEF, 0);
    issue(1'b1, 1'b0, F3_LW, 32'h1000_0000, 32'd0, 0);
    issue(1'b0, 1'b1, F3_SW, 32'h2000_0010, 32'h0BAD_F00D, 0);
    issue(1'b1, 1'b0, F3_LW, 32'h2000_0011, 32'd0, 1);
    issue(1'b1, 1'b0, F3_LH, 32'h2000_0013, 32'd0, 0);
    issue(1'b0, 1'b1, F3_SB, 32'h2000_0011, 32'h0000_00A5, 0);
    issue(1'b1, 1'b1, F3_LB, 32'h2000_0011, 32'h0000_0000, 2);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)
        issue(1'b1, 1'b0, ld_f3[$urandom_range(0, 7)], $urandom, $urandom,
              $urandom_range(0, 2));
      else if (r < 8)
        issue(1'b0, 1'b1, st_f3[$urandom_range(0, 5)], $urandom, $urandom,
              $urandom_range(0, 2));
      else
        issue(1'b1, 1'b1, ld_f3[$urandom_range(0, 7)], $urandom, $urandom,
              $urandom_range(0, 2));
    end

    repeat (5) @(posedge clk);
    chk("bus_left", exp_bus.size(), 32'd0);
    chk("done_left", exp_done.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
